// File: rtl/sdram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_reader
// Purpose  : Avalon-MM burst read master. Takes a job (byte base address and
//            beat count), splits it into bursts of at most MAX_BURST beats,
//            keeps one burst outstanding at a time and streams returned beats
//            to the consumer.
// Options  : SDRAM_RD_TIMEOUT_EN - adds a 10-bit stall watchdog that aborts
//            the job and raises the sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_reader #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int CNT_W     = 11,
  parameter int MAX_BURST = 64,
  parameter int BC_W      = $clog2(MAX_BURST) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_start,
  input  logic [ADDR_W-1:0] read_addr,
  input  logic [CNT_W-1:0]  read_cnt,
  output logic              busy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [BC_W-1:0]   avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int BEAT_BYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remain_q;
  logic [BC_W-1:0]   burst_left_q;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              avm_read_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic [BC_W-1:0]   avm_burstcount_q;

  logic [BC_W-1:0]   start_bc_d;
  logic [BC_W-1:0]   remain_bc_d;
  logic [ADDR_W-1:0] addr_step_d;
  logic              accept_d;
  logic              last_beat_d;

  // Length of the next burst: whatever is left, capped at MAX_BURST.
  function automatic logic [BC_W-1:0] clip_burst(input logic [CNT_W-1:0] n);
    if (n >= CNT_W'(MAX_BURST)) begin
      return BC_W'(MAX_BURST);
    end
    return BC_W'(n);
  endfunction

  // Next-burst sizing, address step and handshake events.
  always_comb begin
    start_bc_d  = clip_burst(read_cnt);
    remain_bc_d = clip_burst(remain_q);
    addr_step_d = ADDR_W'(avm_burstcount_q) * ADDR_W'(BEAT_BYTES);
    accept_d    = (state_q == S_ISSUE) && !avm_waitrequest;
    last_beat_d = (state_q == S_WAIT_DATA) && avm_readdatavalid &&
                  (burst_left_q == BC_W'(1));
  end

`ifdef SDRAM_RD_TIMEOUT_EN
  localparam logic [9:0] WD_LIMIT = 10'd1023;

  logic [9:0] wd_q;
  logic       err_q;
  logic       progress_d;
  logic       timeout_d;

  // Watchdog: any command acceptance or returned beat counts as progress.
  always_comb begin
    progress_d = accept_d || ((state_q == S_WAIT_DATA) && avm_readdatavalid);
    timeout_d  = ((state_q == S_ISSUE) || (state_q == S_WAIT_DATA)) &&
                 !progress_d && (wd_q == WD_LIMIT);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Job FSM with all outputs registered; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cur_addr_q       <= '0;
      remain_q         <= '0;
      burst_left_q     <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      avm_read_q       <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
`ifdef SDRAM_RD_TIMEOUT_EN
      wd_q             <= '0;
      err_q            <= 1'b0;
`endif
    end else begin
      // Beats are forwarded only while a burst is outstanding.
      out_data_q  <= avm_readdata;
      out_valid_q <= avm_readdatavalid && (state_q == S_WAIT_DATA);

`ifdef SDRAM_RD_TIMEOUT_EN
      if (((state_q == S_ISSUE) || (state_q == S_WAIT_DATA)) && !progress_d) begin
        wd_q <= wd_q + 10'd1;
      end else begin
        wd_q <= '0;
      end
`endif

      case (state_q)
        S_IDLE: begin
          if (read_start) begin
            cur_addr_q <= read_addr;
            remain_q   <= read_cnt;
            busy_q     <= 1'b1;
`ifdef SDRAM_RD_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            if (read_cnt == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q          <= S_ISSUE;
              avm_read_q       <= 1'b1;
              avm_address_q    <= read_addr;
              avm_burstcount_q <= start_bc_d;
            end
          end
        end

        S_ISSUE: begin
          if (accept_d) begin
            burst_left_q <= avm_burstcount_q;
            remain_q     <= remain_q - CNT_W'(avm_burstcount_q);
            cur_addr_q   <= cur_addr_q + addr_step_d;
            avm_read_q   <= 1'b0;
            state_q      <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (avm_readdatavalid) begin
            burst_left_q <= burst_left_q - BC_W'(1);
          end
          if (last_beat_d) begin
            if (remain_q != '0) begin
              state_q          <= S_ISSUE;
              avm_read_q       <= 1'b1;
              avm_address_q    <= cur_addr_q;
              avm_burstcount_q <= remain_bc_d;
            end else begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end
          end
        end

        S_FINISH: begin
          // A zero-length job arrives here with done low and spends one
          // extra cycle raising it; data jobs arrive with done already set.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase

`ifdef SDRAM_RD_TIMEOUT_EN
      if (timeout_d) begin
        err_q      <= 1'b1;
        done_q     <= 1'b1;
        avm_read_q <= 1'b0;
        state_q    <= S_FINISH;
      end
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign avm_read       = avm_read_q;
  assign avm_address    = avm_address_q;
  assign avm_burstcount = avm_burstcount_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_burst_reader
// Purpose  : Self-checking bench for sdram_burst_reader. A beat-accounting
//            model predicts every output each cycle; a simple Avalon slave
//            answers commands. Covers the SDRAM_RD_TIMEOUT_EN build as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_burst_reader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         read_start = 1'b0;
  logic [31:0]  read_addr = '0;
  logic [10:0]  read_cnt = '0;
  logic         busy;
  logic [127:0] out_data;
  logic         out_valid;
  logic         done;
  logic         err;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic [6:0]   avm_burstcount;
  logic         avm_waitrequest = 1'b0;
  logic [127:0] avm_readdata = '0;
  logic         avm_readdatavalid = 1'b0;

  sdram_burst_reader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_start       (read_start),
    .read_addr        (read_addr),
    .read_cnt         (read_cnt),
    .busy             (busy),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .done             (done),
    .err              (err),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus-owned knobs ----------------
  int   stall_cfg = 0;
  bit   gap_mode = 1'b0;
  bit   hold_data = 1'b0;
  bit   inject_rdv = 1'b0;
  bit   chk_en = 1'b1;
  bit   model_clr = 1'b0;
  int   start_cyc = 0;

  // ---------------- Avalon slave ----------------
  int          s_beats = 0;
  int          s_pend = 0;
  int          s_stall = 0;
  bit          s_tog = 1'b0;
  logic [31:0] s_word = 32'hC0DE_0000;
  logic [31:0] acc_addr[$];
  int          acc_bc[$];

  always @(negedge clk) begin
    s_beats += s_pend;
    s_pend = 0;
    if (avm_read && s_stall < stall_cfg) begin
      avm_waitrequest = 1'b1;
      s_stall++;
    end else begin
      avm_waitrequest = 1'b0;
      if (avm_read) begin
        s_stall = 0;
        s_pend  = int'(avm_burstcount);
        acc_addr.push_back(avm_address);
        acc_bc.push_back(int'(avm_burstcount));
      end
    end
    if (s_beats > 0 && !hold_data && (!gap_mode || s_tog)) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = {4{s_word}};
      s_word++;
      s_beats--;
    end else begin
      avm_readdatavalid = inject_rdv && (s_beats == 0);
      avm_readdata      = {$urandom, $urandom, $urandom, $urandom};
    end
    s_tog = !s_tog;
  end

  // ---------------- behavioural model ----------------
  // Tracks the job as a list of pending commands plus outstanding beats.
  bit           m_busy = 1'b0, m_read = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_zero = 1'b0;
  int           m_out = 0;
  logic [127:0] m_data = '0;
  logic [31:0]  q_addr[$];
  int           q_bc[$];

  always @(posedge clk or negedge rst_n) begin : model_blk
    int rem;
    int b;
    logic [31:0] a;
    if (!rst_n || model_clr) begin
      m_busy = 0; m_read = 0; m_valid = 0; m_done = 0; m_zero = 0; m_out = 0; m_data = '0;
      q_addr.delete();
      q_bc.delete();
    end
    if (rst_n) begin
      m_valid = avm_readdatavalid && (m_out > 0);
      m_data  = avm_readdata;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_zero) begin
        m_zero = 0;
        m_done = 1;
      end else if (!m_busy) begin
        if (read_start) begin
          m_busy = 1;
          rem = int'(read_cnt);
          a   = read_addr;
          while (rem > 0) begin
            b = (rem > 64) ? 64 : rem;
            q_addr.push_back(a);
            q_bc.push_back(b);
            a   = a + 32'(b * 16);
            rem = rem - b;
          end
          if (q_bc.size() == 0) m_zero = 1;
          else m_read = 1;
        end
      end else if (m_read) begin
        if (!avm_waitrequest) begin
          m_out = q_bc.pop_front();
          void'(q_addr.pop_front());
          m_read = 0;
        end
      end else if (m_out > 0 && avm_readdatavalid) begin
        m_out--;
        if (m_out == 0) begin
          if (q_bc.size() > 0) m_read = 1;
          else m_done = 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_done = 0, n_read = 0;
  int done_cyc = -1, last_valid_cyc = -2;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (out_valid) begin n_valid++; last_valid_cyc = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (avm_read) n_read++;
      if (chk_en) begin
        chk("busy", busy, m_busy);
        chk("avm_read", avm_read, m_read);
        chk("out_valid", out_valid, m_valid);
        chk("done", done, m_done);
        chk("out_data", out_data, m_data);
        chk("err", err, 1'b0);
        if (m_read && q_addr.size() > 0) begin
          chk("avm_address", avm_address, q_addr[0]);
          chk("avm_burstcount", avm_burstcount, q_bc[0]);
        end
        if (!rst_n) begin
          chk("rst_address", avm_address, 0);
          chk("rst_burstcount", avm_burstcount, 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [31:0] a, input logic [10:0] c);
    tick();
    read_addr  = a;
    read_cnt   = c;
    read_start = 1'b1;
    start_cyc  = cyc;
    tick();
    read_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((busy || s_beats > 0 || s_pend > 0) && k < budget);
    chk("idle_reached", busy || s_beats > 0 || s_pend > 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int a0, v0, d0, r0, k, saved;
    fork
      compare_loop();
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_avm_read", avm_read, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single beat, no stall
    a0 = acc_addr.size(); v0 = n_valid; d0 = n_done;
    start_job(32'h0000_1000, 11'd1);
    wait_idle(100);
    chk("t1_cmds", acc_addr.size() - a0, 1);
    chk("t1_addr", acc_addr[a0], 32'h0000_1000);
    chk("t1_bc", acc_bc[a0], 1);
    chk("t1_valids", n_valid - v0, 1);
    chk("t1_dones", n_done - d0, 1);
    chk("t1_done_with_valid", done_cyc, last_valid_cyc);

    // Burst split with stalls and bubbles
    stall_cfg = 2; gap_mode = 1'b1;
    a0 = acc_addr.size(); v0 = n_valid; d0 = n_done;
    start_job(32'h0002_0000, 11'd177);
    wait_idle(2000);
    chk("t2_cmds", acc_addr.size() - a0, 3);
    chk("t2_bc0", acc_bc[a0], 64);
    chk("t2_bc1", acc_bc[a0+1], 64);
    chk("t2_bc2", acc_bc[a0+2], 49);
    chk("t2_addr0", acc_addr[a0], 32'h0002_0000);
    chk("t2_addr1", acc_addr[a0+1], 32'h0002_0400);
    chk("t2_addr2", acc_addr[a0+2], 32'h0002_0800);
    chk("t2_valids", n_valid - v0, 177);
    chk("t2_dones", n_done - d0, 1);

    // Waitrequest stall of 5 cycles with unsolicited readdatavalid around it
    stall_cfg = 5; gap_mode = 1'b0; inject_rdv = 1'b1;
    a0 = acc_addr.size(); v0 = n_valid; d0 = n_done; r0 = n_read;
    start_job(32'h0000_3000, 11'd8);
    wait_idle(200);
    inject_rdv = 1'b0;
    chk("t3_cmds", acc_addr.size() - a0, 1);
    chk("t3_read_cycles", n_read - r0, 6);
    chk("t3_valids", n_valid - v0, 8);
    chk("t3_dones", n_done - d0, 1);

    // Zero length, then a second start while busy
    stall_cfg = 0;
    a0 = acc_addr.size(); d0 = n_done; r0 = n_read;
    tick();
    read_addr = 32'h0000_4000; read_cnt = 11'd0; read_start = 1'b1;
    start_cyc = cyc;
    tick();
    read_addr = 32'h0000_5000; read_cnt = 11'd5;
    tick();
    read_start = 1'b0;
    wait_idle(50);
    repeat (5) tick();
    chk("t4_done_latency", done_cyc - start_cyc, 2);
    chk("t4_dones", n_done - d0, 1);
    chk("t4_read_cycles", n_read - r0, 0);
    chk("t4_cmds", acc_addr.size() - a0, 0);

    // Reset after 10 of 64 beats
    v0 = n_valid;
    start_job(32'h0000_6000, 11'd64);
    k = 0;
    while (n_valid - v0 < 10 && k < 300) begin tick(); k++; end
    chk("t5_reached_10", n_valid - v0 >= 10, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_avm_read", avm_read, 0);
    chk("t5_avm_address", avm_address, 0);
    chk("t5_avm_burstcount", avm_burstcount, 0);
    saved = n_valid;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_idle(200);
    chk("t5_late_dropped", n_valid, saved);

`ifdef SDRAM_RD_TIMEOUT_EN
    // Watchdog abort when data is withheld
    chk_en = 1'b0; hold_data = 1'b1;
    d0 = n_done;
    start_job(32'h0000_7000, 11'd4);
    k = 0;
    while (n_done == d0 && k < 1300) begin tick(); k++; end
    chk("t6_err_set", err, 1);
    chk("t6_dones", n_done - d0, 1);
    chk("t6_latency_window", (done_cyc - start_cyc >= 1023) && (done_cyc - start_cyc <= 1030), 1);
    hold_data = 1'b0;
    wait_idle(100);
    chk("t6_err_sticky", err, 1);
    v0 = n_valid;
    model_clr = 1'b1;
    start_job(32'h0000_8000, 11'd1);
    model_clr = 1'b0;
    chk_en = 1'b1;
    chk("t6_err_cleared", err, 0);
    wait_idle(100);
    chk("t6_valids", n_valid - v0, 1);
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdram_burst_reader.md
# sdram_burst_reader

Avalon-MM burst read master that sits directly upstream of the STMM parameter fetcher. It accepts a job (byte base address, total beat count) over the `sdram_read` handshake, splits it into legal Avalon bursts of at most `MAX_BURST` beats, and streams returned words to the consumer as `out_data`/`out_valid`. It owns the SDRAM-side protocol: waitrequest stalls, burst splitting, address stepping and beat accounting. The fetcher only counts beats.

## Interface
- `ADDR_W`, 32, Avalon byte-address width.
- `DATA_W`, 128, Avalon data width; one beat = `DATA_W/8` bytes.
- `CNT_W`, 11, width of the total beat count per job.
- `MAX_BURST`, 64, largest burst issued; power of two.
- `BC_W`, `$clog2(MAX_BURST)+1`, burstcount width (7 at default).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `read_start`  in  1  single-cycle job request.
- `read_addr`  in  ADDR_W  job byte base address; must be `DATA_W/8`-aligned.
- `read_cnt`  in  CNT_W  total beats in the job.
- `busy`  out  1  high from accepted start until done.
- `out_data`  out  DATA_W  returned beat.
- `out_valid`  out  1  one-cycle qualifier per beat.
- `done`  out  1  one-cycle pulse when the job ends.
- `err`  out  1  sticky timeout flag (see Configuration).
- `avm_address`  out  ADDR_W  Avalon address.
- `avm_read`  out  1  Avalon read request.
- `avm_burstcount`  out  BC_W  Avalon burst length.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  DATA_W  read data.
- `avm_readdatavalid`  in  1  read data qualifier.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_DATA and FINISH.
- **IDLE**
  - `read_start` latches `read_addr` into `cur_addr` and `read_cnt` into `remain`, then moves to ISSUE.
  - If `read_cnt == 0`, it moves to FINISH instead.
- **ISSUE**
  - Drives `avm_read=1`, `avm_address=cur_addr` and `avm_burstcount=min(remain, MAX_BURST)`.
  - Holds all three stable while `avm_waitrequest=1`.
  - On the cycle `avm_waitrequest=0`, the command is accepted. On that edge:
    - `burst_left` is loaded with the burst length.
    - `remain` decreases by the burst length.
    - `cur_addr` increases by burst length × `DATA_W/8`, modulo 2^ADDR_W.
    - The FSM moves to WAIT_DATA.
- **WAIT_DATA**
  - Each `avm_readdatavalid` decrements `burst_left`.
  - When the last beat arrives, the FSM moves to ISSUE if `remain != 0`, otherwise to FINISH.
- **FINISH**
  - Pulses `done` for one cycle, then returns to IDLE.
- **Outstanding bursts:** only one burst is outstanding at a time; a new command is issued only after the previous burst has fully returned.
- **Data path:** `out_data <= avm_readdata` and `out_valid <= avm_readdatavalid && state==WAIT_DATA`.
  - Unsolicited `readdatavalid` (in any other state) is dropped and never forwarded.
- **Busy:** `read_start` while `busy=1` is ignored; no queuing.
- **Widths:** `remain` is CNT_W bits and `burst_left` is BC_W bits. The maximum job is 2^CNT_W−1 beats, with no overflow.

## Timing
- **Reset values:** state IDLE, and every output is 0: `busy`, `out_valid`, `out_data`, `done`, `err`, `avm_read`, `avm_address`, `avm_burstcount`.
- **Start to first command:** `avm_read` rises the cycle after `read_start` is sampled.
- **Data latency:** `out_valid` follows `avm_readdatavalid` by exactly 1 cycle.
- **Burst boundary:** the next command is issued the cycle after the last beat's `readdatavalid`.
- **Job end:**
  - `done` asserts 1 cycle after the last beat's `readdatavalid`, i.e. in the same cycle as the last `out_valid`.
  - `busy` drops the cycle after `done`.
- **Zero-length job:** `done` pulses 2 cycles after start, with no bus activity.
- **Reset mid-job:** everything clears asynchronously. Any in-flight data from the slave after reset is dropped, because the FSM is in IDLE.

## Configuration
- **`SDRAM_RD_TIMEOUT_EN` defined:**
  - A 10-bit watchdog counts cycles in ISSUE or WAIT_DATA without a command acceptance or a `readdatavalid`.
  - At 1023 it sets `err`. `err` is sticky and cleared only by the next accepted `read_start`.
  - On timeout the FSM goes to FINISH, so `done` pulses and the job is aborted.
- **Macro undefined:** no watchdog exists, `err` is tied to 0, and the FSM waits indefinitely.

## Test plan
- **Single beat, no stall:** `addr=0x1000`, `cnt=1` → one command (`burstcount=1`, address `0x1000`); one `out_valid` carrying the data; `done` in the same cycle as that `out_valid`.
- **Burst split:** `cnt=177` with `MAX_BURST=64` → commands of 64, 64 and 49 beats at `base`, `base+0x400` and `base+0x800`; exactly 177 `out_valid` pulses; one `done`.
- **Waitrequest stall:** hold `waitrequest` for 5 cycles → address and burstcount stay stable for all 5 cycles; exactly one command is accepted.
- **Zero length and busy:** `cnt=0` → `done` 2 cycles after start, `avm_read` never asserts. A second `read_start` while `busy` → ignored, with no second `done`.
- **Reset mid-burst:** assert `rst_n=0` after 10 of 64 beats → all outputs 0 immediately. Late `readdatavalid` pulses produce no `out_valid`.
- **Timeout (with `SDRAM_RD_TIMEOUT_EN`):** withhold data after command acceptance → `err=1` and `done` after 1023 idle cycles. `err` clears on the next accepted start.
